// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg
// Shared definitions for the load/store unit: the 2-bit load control codes
// emitted by the opcode decoder and the unit's state encoding.
package load_store_unit_pkg;

    // Load control codes. Bit 1 set means a memory access; bit 0 then
    // selects load (1) versus store (0).
    localparam logic [1:0] LD_NONE  = 2'b00;
    localparam logic [1:0] LD_ALU   = 2'b01;
    localparam logic [1:0] LD_STORE = 2'b10;
    localparam logic [1:0] LD_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WB     = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/load_store_unit.sv
// load_store_unit
// Executes the decoder's load control code between EX and the register-file
// write port: either passes the ALU result through to writeback, or performs
// a word-aligned data-memory read/write over a req/ack handshake. The
// upstream pipeline is stalled (in_ready low) while an operation is in flight.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready upstream handshake; in_ready is high only in IDLE
//   load_code         00 none, 01 ALU writeback, 10 store, 11 load
//   addr, store_data, alu_result, rd_in   operation operands
//   mem_req/mem_we/mem_addr/mem_wdata     memory request, held until ack
//   mem_ack/mem_rdata memory completion strobe and read data
//   wb_valid/wb_rd/wb_data                one-cycle writeback
//   misalign          one-cycle pulse for a load/store with addr[1:0] != 0
//   timeout           one-cycle pulse when an access is abandoned
//                     (present only when LSU_TIMEOUT_EN is defined)
//
// Optional feature: define LSU_TIMEOUT_EN to abort an access after TIMEOUT
// cycles in ACCESS without mem_ack. Without it, ACCESS waits indefinitely.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        load_code,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [4:0]        rd_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              misalign
`ifdef LSU_TIMEOUT_EN
    ,
    output logic              timeout
`endif
);

    lsu_state_t state, state_next;

    logic              accept;
    logic              is_mem_op;
    logic              aligned;
    logic              is_store_q;
    logic [ADDR_W-3:0] word_addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] data_q;
    logic [4:0]        rd_q;
    logic              misalign_q;

    assign accept    = in_valid && (state == S_IDLE);
    assign is_mem_op = load_code[1];
    assign aligned   = (addr[1:0] == 2'b00);

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;
    logic             timeout_q;

    // The counter holds the number of ACCESS cycles already spent without an
    // ack, so reaching TIMEOUT-1 means this is the last cycle we will wait.
    assign timeout_hit = (state == S_ACCESS) && !mem_ack &&
                         (wait_cnt == CNT_W'(TIMEOUT - 1));

    // Counter is held at zero outside ACCESS so it starts fresh on every entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_hit;
            if (state != S_ACCESS || timeout_hit) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    assign timeout = timeout_q;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Misaligned memory ops and code 00 are consumed in
    // IDLE without leaving it; a store completes straight back to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (load_code == LD_ALU) begin
                        state_next = S_WB;
                    end else if (is_mem_op && aligned) begin
                        state_next = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                if (mem_ack) begin
                    state_next = is_store_q ? S_IDLE : S_WB;
                end
`ifdef LSU_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_next = S_IDLE;
                end
`endif
            end
            S_WB: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Operand capture on accept. data_q first takes the ALU result and is
    // overwritten with read data when a load completes, so WB has one source.
    always_ff @(posedge clk) begin
        if (rst) begin
            is_store_q  <= 1'b0;
            word_addr_q <= '0;
            wdata_q     <= '0;
            data_q      <= '0;
            rd_q        <= '0;
            misalign_q  <= 1'b0;
        end else begin
            misalign_q <= accept && is_mem_op && !aligned;
            if (accept) begin
                is_store_q  <= (load_code == LD_STORE);
                word_addr_q <= addr[ADDR_W-1:2];
                wdata_q     <= store_data;
                data_q      <= alu_result;
                rd_q        <= rd_in;
            end else if (state == S_ACCESS && mem_ack && !is_store_q) begin
                data_q <= mem_rdata;
            end
        end
    end

    // Outputs are decoded from state; the memory and writeback buses read as
    // zero whenever their strobe is low.
    always_comb begin
        in_ready  = (state == S_IDLE);
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        wb_valid  = 1'b0;
        wb_rd     = '0;
        wb_data   = '0;
        misalign  = misalign_q;
        if (state == S_ACCESS) begin
            mem_req   = 1'b1;
            mem_we    = is_store_q;
            mem_addr  = {word_addr_q, 2'b00};
            mem_wdata = wdata_q;
        end
        if (state == S_WB) begin
            wb_valid = 1'b1;
            wb_rd    = rd_q;
            wb_data  = data_q;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// Self-checking bench for load_store_unit: a table of single-operation
// vectors with hand-computed expectations, plus hand-written sequences for
// reset during an access and (when LSU_TIMEOUT_EN is defined) the timeout.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    localparam int MAX_CYC = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  load_code;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] alu_result;
    logic [4:0]  rd_in;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign;
`ifdef LSU_TIMEOUT_EN
    logic        timeout;
`endif

    int total = 0;
    int bad   = 0;

    load_store_unit #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .load_code(load_code),
        .addr(addr),
        .store_data(store_data),
        .alu_result(alu_result),
        .rd_in(rd_in),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .wb_valid(wb_valid),
        .wb_rd(wb_rd),
        .wb_data(wb_data),
        .misalign(misalign)
`ifdef LSU_TIMEOUT_EN
        ,
        .timeout(timeout)
`endif
    );

    always #5 clk = ~clk;

    // Cycle numbers count from the accept edge (cycle 0); 0 in a *_cycle
    // field means "never".
    typedef struct {
        string       name;
        logic [1:0]  code;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] alu;
        logic [4:0]  rd;
        int          ack_cycle;
        logic [31:0] rdata;
        int          exp_req_cycles;
        int          exp_wb_cycle;
        logic [31:0] exp_wb_data;
        logic [4:0]  exp_wb_rd;
        int          exp_mis_cycle;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        int          exp_ready_cycle;
    } vec_t;

    vec_t vecs[10];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Issues one operation, then watches MAX_CYC cycles, driving mem_ack in
    // the requested cycle and recording what the DUT did.
    task automatic applyStimulus(input vec_t v);
        int          req_cycles = 0;
        logic        we_seen = 1'b0;
        logic [31:0] addr_seen = '0;
        logic [31:0] wdata_seen = '0;
        int          wb_cycle = 0;
        int          wb_count = 0;
        logic [31:0] wb_data_seen = '0;
        logic [4:0]  wb_rd_seen = '0;
        int          mis_cycle = 0;
        int          mis_count = 0;
        int          ready_cycle = 0;

        @(negedge clk);
        in_valid   = 1'b1;
        load_code  = v.code;
        addr       = v.addr;
        store_data = v.sdata;
        alu_result = v.alu;
        rd_in      = v.rd;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        load_code = LD_NONE;
        for (int c = 1; c <= MAX_CYC; c++) begin
            mem_ack   = (c == v.ack_cycle);
            mem_rdata = v.rdata;
            @(negedge clk);
            if (mem_req) begin
                req_cycles++;
                we_seen    = we_seen | mem_we;
                addr_seen  = mem_addr;
                wdata_seen = mem_wdata;
            end
            if (wb_valid) begin
                wb_count++;
                if (wb_cycle == 0) wb_cycle = c;
                wb_data_seen = wb_data;
                wb_rd_seen   = wb_rd;
            end
            if (misalign) begin
                mis_count++;
                if (mis_cycle == 0) mis_cycle = c;
            end
            if (in_ready && ready_cycle == 0) ready_cycle = c;
            @(posedge clk);
            #1;
        end
        mem_ack = 1'b0;

        checkOutput({v.name, " req_cycles"}, 32'(req_cycles), 32'(v.exp_req_cycles));
        checkOutput({v.name, " mem_we"}, 32'(we_seen), 32'(v.exp_we));
        checkOutput({v.name, " mem_addr"}, addr_seen, v.exp_addr);
        checkOutput({v.name, " mem_wdata"}, wdata_seen, v.exp_wdata);
        checkOutput({v.name, " wb_cycle"}, 32'(wb_cycle), 32'(v.exp_wb_cycle));
        checkOutput({v.name, " wb_count"}, 32'(wb_count), 32'(v.exp_wb_cycle != 0));
        checkOutput({v.name, " wb_data"}, wb_data_seen, v.exp_wb_data);
        checkOutput({v.name, " wb_rd"}, 32'(wb_rd_seen), 32'(v.exp_wb_rd));
        checkOutput({v.name, " mis_cycle"}, 32'(mis_cycle), 32'(v.exp_mis_cycle));
        checkOutput({v.name, " mis_count"}, 32'(mis_count), 32'(v.exp_mis_cycle != 0));
        checkOutput({v.name, " ready_cycle"}, 32'(ready_cycle), 32'(v.exp_ready_cycle));
    endtask

    initial begin
        int wb_seen;
        int req_seen;

        //           name        code      addr          sdata         alu           rd  ack rdata         req wb data          wbrd mis we    maddr         wdata         rdy
        vecs[0] = '{"alu",       LD_ALU,   32'h0,        32'h0,        32'hDEADBEEF, 5,  0,  32'h0,        0,  1, 32'hDEADBEEF, 5,   0,  1'b0, 32'h0,        32'h0,        2};
        vecs[1] = '{"load_ack3", LD_LOAD,  32'h100,      32'h0,        32'h0,        7,  3,  32'h12345678, 3,  4, 32'h12345678, 7,   0,  1'b0, 32'h100,      32'h0,        5};
        vecs[2] = '{"store_ack1",LD_STORE, 32'h40,       32'hA5A5A5A5, 32'h0,        3,  1,  32'h0,        1,  0, 32'h0,        0,   0,  1'b1, 32'h40,       32'hA5A5A5A5, 2};
        vecs[3] = '{"mis_load",  LD_LOAD,  32'h102,      32'h0,        32'h0,        9,  0,  32'h0,        0,  0, 32'h0,        0,   1,  1'b0, 32'h0,        32'h0,        1};
        vecs[4] = '{"none",      LD_NONE,  32'h0,        32'h0,        32'h55,       4,  0,  32'h0,        0,  0, 32'h0,        0,   0,  1'b0, 32'h0,        32'h0,        1};
        vecs[5] = '{"load_r0",   LD_LOAD,  32'h3FC,      32'h0,        32'h0,        0,  1,  32'hCAFEF00D, 1,  2, 32'hCAFEF00D, 0,   0,  1'b0, 32'h3FC,      32'h0,        3};
        vecs[6] = '{"mis_store", LD_STORE, 32'h41,       32'h11111111, 32'h0,        2,  0,  32'h0,        0,  0, 32'h0,        0,   1,  1'b0, 32'h0,        32'h0,        1};
        vecs[7] = '{"alu_stray", LD_ALU,   32'h0,        32'h0,        32'h00000001, 31, 1,  32'hFFFFFFFF, 0,  1, 32'h00000001, 31,  0,  1'b0, 32'h0,        32'h0,        2};
        vecs[8] = '{"store_ack2",LD_STORE, 32'h44,       32'h00001234, 32'h0,        1,  2,  32'h0,        2,  0, 32'h0,        0,   0,  1'b1, 32'h44,       32'h00001234, 3};
        vecs[9] = '{"load_top",  LD_LOAD,  32'hFFFFFFFC, 32'h0,        32'h0,        12, 2,  32'h0F0F0F0F, 2,  3, 32'h0F0F0F0F, 12,  0,  1'b0, 32'hFFFFFFFC, 32'h0,        4};

        rst        = 1'b1;
        in_valid   = 1'b0;
        load_code  = LD_NONE;
        addr       = '0;
        store_data = '0;
        alu_result = '0;
        rd_in      = '0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        @(negedge clk);
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset mem_req", 32'(mem_req), 32'd0);
        checkOutput("reset wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("reset misalign", 32'(misalign), 32'd0);
        checkOutput("reset mem_addr", mem_addr, 32'd0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
        end

        // Reset in cycle 2 of a load: request is dropped, a late ack ignored.
        @(negedge clk);
        in_valid  = 1'b1;
        load_code = LD_LOAD;
        addr      = 32'h80;
        rd_in     = 5'd6;
        mem_rdata = 32'h77777777;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        load_code = LD_NONE;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstmid req_c2", 32'(mem_req), 32'd1);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        checkOutput("rstmid req_c3", 32'(mem_req), 32'd0);
        checkOutput("rstmid ready_c3", 32'(in_ready), 32'd1);
        wb_seen  = 0;
        req_seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            @(negedge clk);
            if (wb_valid) wb_seen++;
            if (mem_req) req_seen++;
        end
        checkOutput("rstmid late_wb", 32'(wb_seen), 32'd0);
        checkOutput("rstmid late_req", 32'(req_seen), 32'd0);

`ifdef LSU_TIMEOUT_EN
        begin
            int to_cycle = 0;
            int to_count = 0;
            int ready_c  = 0;
            req_seen = 0;
            wb_seen  = 0;
            @(negedge clk);
            in_valid  = 1'b1;
            load_code = LD_LOAD;
            addr      = 32'h10;
            @(posedge clk);
            #1;
            in_valid  = 1'b0;
            load_code = LD_NONE;
            for (int c = 1; c <= MAX_CYC; c++) begin
                @(negedge clk);
                if (mem_req) req_seen++;
                if (wb_valid) wb_seen++;
                if (timeout) begin
                    to_count++;
                    if (to_cycle == 0) to_cycle = c;
                end
                if (in_ready && ready_c == 0) ready_c = c;
                @(posedge clk);
                #1;
            end
            checkOutput("timeout req_cycles", 32'(req_seen), 32'd4);
            checkOutput("timeout cycle", 32'(to_cycle), 32'd5);
            checkOutput("timeout count", 32'(to_count), 32'd1);
            checkOutput("timeout wb", 32'(wb_seen), 32'd0);
            checkOutput("timeout ready", 32'(ready_c), 32'd5);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Executes the 2-bit Load control code that the opcode decoder emits. Performs the data-memory read or write over a req/ack handshake, or passes the ALU result straight through, then presents the writeback.
- Sits between EX and the register-file write port.
- Stalls the upstream pipeline through in_ready while a memory access is outstanding.

Parameters:
- ADDR_W, 32, data-memory byte-address width
- DATA_W, 32, data word width
- TIMEOUT, 15, cycles to wait for mem_ack before aborting (used only with the optional feature)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream operation valid
- in_ready  out  1  unit can accept an operation; high only in IDLE
- load_code  in  2  00 none, 01 ALU writeback, 11 load word, 10 store word
- addr  in  ADDR_W  effective address (load/store)
- store_data  in  DATA_W  store data
- alu_result  in  DATA_W  value for code 01
- rd_in  in  5  destination register
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  word-aligned address
- mem_wdata  out  DATA_W  write data
- mem_ack  in  1  memory completion, one cycle
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- wb_valid  out  1  one-cycle writeback strobe
- wb_rd  out  5  writeback register
- wb_data  out  DATA_W  writeback value
- misalign  out  1  one-cycle pulse: load/store with addr[1:0] != 0

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE
  - all outputs 0, except in_ready = 1
  - an outstanding request is dropped; mem_req is low the cycle after rst is sampled.
- Accept condition: in_valid && in_ready. On accept, register load_code, addr, store_data, alu_result and rd_in.
- States are IDLE, ACCESS, WB.
- IDLE, on accept:
  - code 00: stay in IDLE; no outputs.
  - code 01: go to WB with wb_data = alu_result.
  - code 10/11 with addr[1:0] != 0: pulse misalign next cycle, no memory access, stay in IDLE.
  - code 10/11 aligned: go to ACCESS.
- ACCESS:
  - mem_req = 1; mem_we = (code == 10); mem_addr and mem_wdata stable.
  - All memory outputs are held until mem_ack is sampled high.
  - On mem_ack, load: capture mem_rdata and go to WB.
  - On mem_ack, store: return to IDLE; there is no writeback.
- WB: wb_valid = 1 for exactly one cycle, then IDLE.
- Latency, counted from the accept edge (cycle 0):
  - ALU pass: wb_valid in cycle 1.
  - Load: mem_req from cycle 1; with ack in cycle k, wb_valid in cycle k+1.
  - Store: in_ready is high again in the cycle after ack.
- in_ready = (state == IDLE). Back-to-back ALU passes therefore sustain one op every 2 cycles.
- wb_rd = 0 with wb_valid: the strobe is still issued; the register file ignores r0.
- mem_ack while not in ACCESS is ignored.
- mem_addr is registered addr with bits [1:0] forced to 0.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined:
  - ACCESS counts cycles.
  - After TIMEOUT cycles without ack: drop mem_req, pulse output port timeout for one cycle, return to IDLE, no writeback.
  - The counter clears on entry to ACCESS.
- Undefined: the timeout port and counter are absent, and ACCESS waits indefinitely.

Decomposition:
- Shared package holds:
  - Load code constants: LD_NONE = 00, LD_ALU = 01, LD_STORE = 10, LD_LOAD = 11.
  - The state enum.
- No sub-module is needed. The timeout counter stays inline under the macro.

Test Plan:
1. ALU pass: code 01, alu_result = 32'hDEAD_BEEF, rd_in = 5 -> wb_valid in cycle 1 with wb_rd = 5 and wb_data = DEADBEEF; no mem_req.
2. Load, ack delayed 3 cycles: code 11, addr = 0x100, mem_rdata = 0x1234_5678 -> mem_req high cycles 1–3, mem_we = 0, wb_data = 12345678 in cycle 4, in_ready low cycles 1–4.
3. Store: code 10, addr = 0x40, store_data = 0xA5A5_A5A5, immediate ack -> mem_we = 1, mem_wdata = A5A5A5A5, no wb_valid, in_ready high in cycle 2.
4. Misaligned: code 11, addr = 0x102 -> misalign pulse in cycle 1; mem_req never asserts.
5. Reset mid-operation: rst asserted in cycle 2 of a load -> mem_req = 0 and in_ready = 1 in the next cycle; a late mem_ack is ignored and wb_valid stays 0.
6. Timeout (LSU_TIMEOUT_EN defined, TIMEOUT = 4): load with no ack -> timeout pulse after 4 ACCESS cycles, no wb_valid, returns to IDLE.
